// File: rtl/lora_pkg.sv
// -----------------------------------------------------------------------------
// lora_pkg
// Shared definitions for the LoRa UART frame receiver:
//   - parser_state_t : parser state encoding (IDLE, CMD, CHK)
//   - HDR_DEFAULT    : default frame header byte
//   - FRAME_LEN_*    : frame length in bytes with / without checksum byte
//   - lora_chksum()  : checksum byte expected after the command byte
//   - cmd_fits()     : true when the command has no bits above the flag width
// -----------------------------------------------------------------------------
package lora_pkg;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_CMD  = 2'd1,
    P_CHK  = 2'd2
  } parser_state_t;

  localparam logic [7:0] HDR_DEFAULT     = 8'hA5;
  localparam int         FRAME_LEN_CHK   = 3;
  localparam int         FRAME_LEN_NOCHK = 2;

  function automatic logic [7:0] lora_chksum(input logic [7:0] hdr, input logic [7:0] cmd);
    return hdr ^ cmd;
  endfunction

  // Shifting by the flag width leaves only the must-be-zero bits; for an
  // 8-bit flag the shift clears everything, so the check always passes.
  function automatic logic cmd_fits(input logic [7:0] cmd, input int flag_w);
    return (cmd >> flag_w) == 8'd0;
  endfunction

endpackage

// File: rtl/lora_uart_byte_rx.sv
// -----------------------------------------------------------------------------
// lora_uart_byte_rx
// 8N1 UART byte receiver with a 2-flop input synchroniser.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   line     in   asynchronous UART line, idle high
//   data     out  last received byte (held until the next good byte)
//   data_vld out  one-cycle pulse: byte received with a valid stop bit
//   stop_err out  one-cycle pulse: byte received with stop bit 0 (discarded)
// Parameter DIV is the number of clock cycles per bit (>= 16).
// -----------------------------------------------------------------------------
module lora_uart_byte_rx #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line,
  output logic [7:0] data,
  output logic       data_vld,
  output logic       stop_err
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          prev_r;
  logic          active_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    bit_r;     // 0 = start bit, 1..8 = data bits, 9 = stop bit
  logic [7:0]    shift_r;
  logic          nedge_s;

  assign nedge_s = prev_r & ~sync2_r;

  // Synchroniser, start detection and bit sampling at mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      prev_r   <= 1'b1;
      active_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      bit_r    <= 4'd0;
      shift_r  <= 8'd0;
      data     <= 8'd0;
      data_vld <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      sync1_r  <= line;
      sync2_r  <= sync1_r;
      prev_r   <= sync2_r;
      data_vld <= 1'b0;
      stop_err <= 1'b0;
      if (!active_r) begin
        if (nedge_s) begin
          active_r <= 1'b1;
          cnt_r    <= HALF_M1;
          bit_r    <= 4'd0;
        end
      end else if (cnt_r != {CW{1'b0}}) begin
        cnt_r <= cnt_r - CW'(1);
      end else begin
        cnt_r <= FULL_M1;
        if (bit_r == 4'd0) begin
          // A line that is high again at mid start bit was only a glitch.
          if (sync2_r) begin
            active_r <= 1'b0;
          end else begin
            bit_r <= 4'd1;
          end
        end else if (bit_r <= 4'd8) begin
          shift_r <= {sync2_r, shift_r[7:1]};
          bit_r   <= bit_r + 4'd1;
        end else begin
          // Going idle at mid stop bit lets a back-to-back start bit be seen.
          active_r <= 1'b0;
          if (sync2_r) begin
            data     <= shift_r;
            data_vld <= 1'b1;
          end else begin
            stop_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/lora_frame_rx.sv
// -----------------------------------------------------------------------------
// lora_frame_rx
// Receives command frames from the LoRa module over UART and latches the
// command flag for the downstream controller.
// Frame: HDR, cmd [, HDR^cmd when LORA_RX_CHKSUM_EN is defined].
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   data_rx   in   UART line, asynchronous, idle high
//   over_all  in   one-cycle request: clear flag_lora, abort frame in progress
//   flag_lora out  last accepted command flag (FLAG_W bits)
//   flag_vld  out  one-cycle pulse when flag_lora is updated
//   over_rx   out  one-cycle pulse per correctly framed byte
//   frame_err out  one-cycle pulse on stop-bit, content, checksum or timeout error
//   busy      out  parser is past IDLE
// Build option: LORA_RX_CHKSUM_EN adds the checksum byte and CHK state.
// -----------------------------------------------------------------------------
module lora_frame_rx
  import lora_pkg::*;
#(
  parameter int         CLK_HZ   = 50000000,
  parameter int         BAUD     = 115200,
  parameter int         FLAG_W   = 2,
  parameter logic [7:0] HDR      = HDR_DEFAULT,
  parameter int         TO_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_rx,
  input  logic              over_all,
  output logic [FLAG_W-1:0] flag_lora,
  output logic              flag_vld,
  output logic              over_rx,
  output logic              frame_err,
  output logic              busy
);

  localparam int            DIV     = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int            TO_CYC  = TO_BYTES * 10 * DIV;
  localparam int            TW      = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  logic [7:0]        byte_s;
  logic              byte_vld_s;
  logic              stop_err_s;

  logic [7:0]        rx_byte_r;
  logic              byte_evt_r;
  parser_state_t     state_r;
  parser_state_t     state_n;
  logic [TW-1:0]     to_cnt_r;
  logic [TW-1:0]     to_cnt_n;
  logic [FLAG_W-1:0] flag_r;
  logic [FLAG_W-1:0] flag_n;
  logic              flag_vld_r;
  logic              flag_vld_n;
  logic              frame_err_r;
  logic              perr_n;
  logic              busy_r;
  logic              commit_s;
  logic [7:0]        commit_cmd_s;
`ifdef LORA_RX_CHKSUM_EN
  logic [7:0]        cmd_r;
  logic [7:0]        cmd_n;
`endif

  lora_uart_byte_rx #(
    .DIV (DIV)
  ) u_byte_rx (
    .clk      (clk),
    .rst      (rst),
    .line     (data_rx),
    .data     (byte_s),
    .data_vld (byte_vld_s),
    .stop_err (stop_err_s)
  );

  // Parser next state, commit decision and inter-byte timeout.
  always_comb begin
    state_n      = state_r;
    to_cnt_n     = to_cnt_r;
    flag_n       = flag_r;
    flag_vld_n   = 1'b0;
    perr_n       = 1'b0;
    commit_s     = 1'b0;
    commit_cmd_s = rx_byte_r;
`ifdef LORA_RX_CHKSUM_EN
    cmd_n        = cmd_r;
`endif
    if (over_all) begin
      // Abort wins over a commit decided in the same cycle.
      flag_n   = {FLAG_W{1'b0}};
      state_n  = P_IDLE;
      to_cnt_n = {TW{1'b0}};
    end else if (byte_evt_r) begin
      to_cnt_n = {TW{1'b0}};
      case (state_r)
        P_IDLE: begin
          if (rx_byte_r == HDR) begin
            state_n = P_CMD;
          end else begin
            state_n = P_IDLE;
          end
        end
        P_CMD: begin
`ifdef LORA_RX_CHKSUM_EN
          cmd_n   = rx_byte_r;
          state_n = P_CHK;
`else
          commit_s     = 1'b1;
          commit_cmd_s = rx_byte_r;
          state_n      = P_IDLE;
`endif
        end
`ifdef LORA_RX_CHKSUM_EN
        P_CHK: begin
          state_n = P_IDLE;
          if (rx_byte_r == lora_chksum(HDR, cmd_r)) begin
            commit_s     = 1'b1;
            commit_cmd_s = cmd_r;
          end else begin
            perr_n = 1'b1;
          end
        end
`endif
        default: begin
          state_n = P_IDLE;
        end
      endcase
    end else if (state_r == P_IDLE) begin
      to_cnt_n = {TW{1'b0}};
    end else if (to_cnt_r == TO_LAST) begin
      perr_n   = 1'b1;
      state_n  = P_IDLE;
      to_cnt_n = {TW{1'b0}};
    end else begin
      to_cnt_n = to_cnt_r + TW'(1);
    end

    if (commit_s) begin
      if (cmd_fits(commit_cmd_s, FLAG_W)) begin
        flag_n     = commit_cmd_s[FLAG_W-1:0];
        flag_vld_n = 1'b1;
      end else begin
        perr_n = 1'b1;
      end
    end else begin
      flag_vld_n = 1'b0;
    end
  end

  // Parser registers and registered outputs. Stop-bit errors are registered
  // alongside over_rx so they land in the cycle the byte would have.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte_r   <= 8'd0;
      byte_evt_r  <= 1'b0;
      state_r     <= P_IDLE;
      to_cnt_r    <= {TW{1'b0}};
      flag_r      <= {FLAG_W{1'b0}};
      flag_vld_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef LORA_RX_CHKSUM_EN
      cmd_r       <= 8'd0;
`endif
    end else begin
      rx_byte_r   <= byte_s;
      byte_evt_r  <= byte_vld_s;
      state_r     <= state_n;
      to_cnt_r    <= to_cnt_n;
      flag_r      <= flag_n;
      flag_vld_r  <= flag_vld_n;
      frame_err_r <= stop_err_s | perr_n;
      busy_r      <= (state_n != P_IDLE);
`ifdef LORA_RX_CHKSUM_EN
      cmd_r       <= cmd_n;
`endif
    end
  end

  assign flag_lora = flag_r;
  assign flag_vld  = flag_vld_r;
  assign over_rx   = byte_evt_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule
